miner_job_dispatcher: RTL and testbench

- Host-side initiator for the miner core. It accepts a mining job (nonce range plus 256-bit target) over a valid/ready handshake.
- For each nonce it pulses hash_enable into miner_core_CCU, then waits for that controller's finished response.
- Each returned hash is compared against the target. The block reports the first winning nonce, range exhaustion, or a core timeout.
- It is the opposite end of the CCU's hash_enable/finished protocol.

---
 rtl/miner_job_dispatcher.sv | 164 ++++++++++++++++
 tb/tb_miner_job_dispatcher.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : miner_job_dispatcher
// Purpose  : Sweeps a nonce range through miner_core_CCU and reports the
//            first nonce whose digest is <= target, range end, or a timeout.
// Revision : 1.0
// ============================================================================
module miner_job_dispatcher #(
    parameter int TIMEOUT_CYCLES = 512,
    parameter int TW             = 10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [31:0]  start_nonce,
    input  logic [31:0]  nonce_limit,
    input  logic [255:0] target,
    input  logic         abort,
    output logic         hash_enable,
    output logic [31:0]  nonce_out,
    input  logic         finished,
    input  logic [255:0] hash_in,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         result_found,
    output logic         result_timeout,
    output logic [31:0]  result_nonce,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t         state_q;
    logic [31:0]    nonce_q;
    logic [31:0]    limit_q;
    logic [255:0]   target_q;
    logic [255:0]   hash_q;
    logic [TW-1:0]  tmo_q;
    logic           hash_enable_q;
    logic [31:0]    nonce_out_q;
    logic           busy_q;
    logic           result_valid_q;
    logic           result_found_q;
    logic           result_timeout_q;
    logic [31:0]    result_nonce_q;

    logic [31:0]    nonce_d;
    logic           hash_win_d;
    logic           range_end_d;
    logic           tmo_hit_d;

    assign nonce_d     = nonce_q + 32'd1;
    assign hash_win_d  = (hash_q <= target_q);
    assign range_end_d = (nonce_q == limit_q);
    assign tmo_hit_d   = (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q          <= S_IDLE;
            nonce_q          <= '0;
            limit_q          <= '0;
            target_q         <= '0;
            hash_q           <= '0;
            tmo_q            <= '0;
            hash_enable_q    <= 1'b0;
            nonce_out_q      <= '0;
            busy_q           <= 1'b0;
            result_valid_q   <= 1'b0;
            result_found_q   <= 1'b0;
            result_timeout_q <= 1'b0;
            result_nonce_q   <= '0;
        end else begin
            // hash_enable is a single-cycle pulse raised only on entry to LAUNCH
            hash_enable_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (job_valid) begin
                        nonce_q       <= start_nonce;
                        limit_q       <= nonce_limit;
                        target_q      <= target;
                        nonce_out_q   <= start_nonce;
                        hash_enable_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    tmo_q <= '0;
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (finished) begin
                        hash_q  <= hash_in;
                        state_q <= S_CHECK;
                    end else if (tmo_hit_d) begin
                        result_valid_q   <= 1'b1;
                        result_found_q   <= 1'b0;
                        result_timeout_q <= 1'b1;
                        result_nonce_q   <= nonce_q;
                        state_q          <= S_REPORT;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (hash_win_d || range_end_d) begin
                        result_valid_q   <= 1'b1;
                        result_found_q   <= hash_win_d;
                        result_timeout_q <= 1'b0;
                        result_nonce_q   <= nonce_q;
                        state_q          <= S_REPORT;
                    end else begin
                        // 32-bit add wraps naturally for ranges crossing 0xFFFFFFFF
                        nonce_q       <= nonce_d;
                        nonce_out_q   <= nonce_d;
                        hash_enable_q <= 1'b1;
                        state_q       <= S_LAUNCH;
                    end
                end
                S_REPORT: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign job_ready      = (state_q == S_IDLE);
    assign hash_enable    = hash_enable_q;
    assign nonce_out      = nonce_out_q;
    assign busy           = busy_q;
    assign result_valid   = result_valid_q;
    assign result_found   = result_found_q;
    assign result_timeout = result_timeout_q;
    assign result_nonce   = result_nonce_q;

endmodule
`default_nettype wire

// File: tb/tb_miner_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_miner_job_dispatcher
// Purpose  : Directed bench with a core model and a queue-based scoreboard.
// Revision : 1.0
// ============================================================================
module tb_miner_job_dispatcher;

    localparam int TMO = 512;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         job_valid;
    logic         job_ready;
    logic [31:0]  start_nonce;
    logic [31:0]  nonce_limit;
    logic [255:0] target;
    logic         abort;
    logic         hash_enable;
    logic [31:0]  nonce_out;
    logic         finished;
    logic [255:0] hash_in;
    logic         result_valid;
    logic         result_ready;
    logic         result_found;
    logic         result_timeout;
    logic [31:0]  result_nonce;
    logic         busy;

    miner_job_dispatcher #(
        .TIMEOUT_CYCLES(TMO),
        .TW            (10)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .start_nonce   (start_nonce),
        .nonce_limit   (nonce_limit),
        .target        (target),
        .abort         (abort),
        .hash_enable   (hash_enable),
        .nonce_out     (nonce_out),
        .finished      (finished),
        .hash_in       (hash_in),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_found  (result_found),
        .result_timeout(result_timeout),
        .result_nonce  (result_nonce),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Scoreboard queues: launched nonces and {found, timeout, nonce} results
    logic [31:0] exp_nonce[$];
    logic [33:0] exp_res[$];

    // Core model knobs, written by the stimulus between jobs
    int           lat          = 20;
    int           mode         = 0;    // 0: fixed hash, 1: hash 0 only at win_nonce, 2: never answer
    logic [255:0] hash_val     = '0;
    logic [31:0]  win_nonce    = '0;
    bit           abort_on_fin = 1'b0;
    int           last_launch_cyc = 0;
    int           last_fin_cyc    = 0;

    initial begin
        bit          pend;
        int          fin_at;
        logic [31:0] pnonce;
        pend = 1'b0; fin_at = 0; pnonce = '0;
        finished = 1'b0; abort = 1'b0; hash_in = '0;
        forever begin
            @(posedge clk); #1;
            finished = 1'b0; abort = 1'b0; hash_in = '0;
            if (pend && cyc == fin_at) begin
                pend         = 1'b0;
                finished     = 1'b1;
                abort        = abort_on_fin;
                last_fin_cyc = cyc;
                if (mode == 1) hash_in = (pnonce == win_nonce) ? '0 : '1;
                else           hash_in = hash_val;
            end
            if (hash_enable === 1'b1) begin
                last_launch_cyc = cyc;
                if (mode != 2) begin
                    pend   = 1'b1;
                    fin_at = cyc + lat;
                    pnonce = nonce_out;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT launches or hands over a result
    logic prev_he = 1'b0;
    always @(negedge clk) begin
        if (hash_enable === 1'b1) begin
            chk("he_not_back_to_back", {71'd0, prev_he}, 72'd0);
            if (exp_nonce.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_launch: actual nonce=%0h required=no launch", nonce_out);
            end else begin
                chk("launch_nonce", {40'd0, nonce_out}, {40'd0, exp_nonce.pop_front()});
            end
        end
        prev_he <= hash_enable;
        if (result_valid === 1'b1 && result_ready === 1'b1) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: actual=%0h required=no result",
                         {result_found, result_timeout, result_nonce});
            end else begin
                chk("result", {38'd0, result_found, result_timeout, result_nonce},
                    {38'd0, exp_res.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_job(input logic [31:0] s, input logic [31:0] l, input logic [255:0] t);
        int n = 0;
        while (job_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("job_ready_before_send", {71'd0, job_ready}, 72'd1);
        start_nonce = s; nonce_limit = l; target = t; job_valid = 1'b1;
        tick();
        // Scramble inputs so any re-sampling after acceptance shows up
        job_valid = 1'b0; start_nonce = ~s; nonce_limit = ~l; target = ~t;
        chk("launch_state", {69'd0, busy, hash_enable, job_ready}, 72'b110);
    endtask

    task automatic wait_rv(input int budget, output int at_cyc);
        int n = 0;
        while (result_valid !== 1'b1 && n < budget) begin tick(); n++; end
        chk("result_valid_seen", {71'd0, result_valid}, 72'd1);
        at_cyc = cyc;
    endtask

    task automatic wait_fin(input int budget);
        int n = 0;
        @(negedge clk);
        while (finished !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk("finished_seen", {71'd0, finished}, 72'd1);
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick();
        chk("idle_after_accept", {69'd0, job_ready, result_valid, busy}, 72'b100);
        result_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int rv_cyc;
        n_rst = 1'b0; job_valid = 1'b0; start_nonce = '0; nonce_limit = '0;
        target = '0; result_ready = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {2'd0, hash_enable, nonce_out, result_valid, result_found,
                              result_timeout, result_nonce, busy, job_ready}, 72'd1);
        n_rst = 1'b1;
        tick();
        chk("idle_ready", {70'd0, job_ready, busy}, 72'b10);

        // Single-nonce hit at full core latency
        lat = 338; mode = 0; hash_val = 256'h1234;
        exp_nonce.push_back(32'h10);
        exp_res.push_back({1'b1, 1'b0, 32'h10});
        send_job(32'h10, 32'h10, '1);
        wait_rv(2000, rv_cyc);
        chk("hit_rv_after_finished", 72'(rv_cyc - last_fin_cyc), 72'd2);
        chk("hit_rv_after_launch", 72'(rv_cyc - last_launch_cyc), 72'd340);
        accept();

        // Range exhaustion: hash 1 never beats target 0
        lat = 20; hash_val = 256'h1;
        for (int n = 5; n <= 8; n++) exp_nonce.push_back(32'(n));
        exp_res.push_back({1'b0, 1'b0, 32'd8});
        send_job(32'd5, 32'd8, '0);
        wait_rv(2000, rv_cyc);
        accept();

        // Wrap through 0xFFFFFFFF, win at nonce 1
        mode = 1; win_nonce = 32'd1;
        exp_nonce.push_back(32'hFFFF_FFFE);
        exp_nonce.push_back(32'hFFFF_FFFF);
        exp_nonce.push_back(32'h0000_0000);
        exp_nonce.push_back(32'h0000_0001);
        exp_res.push_back({1'b1, 1'b0, 32'd1});
        send_job(32'hFFFF_FFFE, 32'd2, 256'h100);
        wait_rv(2000, rv_cyc);
        accept();

        // Core never answers: WAIT lasts TMO cycles, REPORT follows
        mode = 2;
        exp_nonce.push_back(32'h99);
        exp_res.push_back({1'b0, 1'b1, 32'h99});
        send_job(32'h99, 32'h9A, '1);
        wait_rv(2000, rv_cyc);
        chk("timeout_latency", 72'(rv_cyc - last_launch_cyc), 72'(TMO + 1));
        accept();

        // Abort coincident with finished; the hash would have won
        mode = 0; lat = 30; hash_val = '0; abort_on_fin = 1'b1;
        exp_nonce.push_back(32'h40);
        send_job(32'h40, 32'h50, '1);
        wait_fin(200);
        tick();
        chk("abort_to_idle", {69'd0, busy, job_ready, result_valid}, 72'b010);
        abort_on_fin = 1'b0; lat = 25; hash_val = 256'hABCD;

        // Immediate new job; hash equal to target wins; result backpressured
        exp_nonce.push_back(32'h77);
        exp_res.push_back({1'b1, 1'b0, 32'h77});
        send_job(32'h77, 32'h77, 256'hABCD);
        wait_rv(2000, rv_cyc);
        for (int i = 0; i < 10; i++) begin
            chk("backpressure_hold",
                {35'd0, result_valid, job_ready, busy, result_found, result_timeout, result_nonce},
                {35'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h77});
            tick();
        end
        accept();

        // Synchronous reset mid-WAIT, then a stray finished
        lat = 60; hash_val = '0;
        exp_nonce.push_back(32'h5);
        send_job(32'h5, 32'h5, '1);
        repeat (10) tick();
        n_rst = 1'b0;
        tick();
        chk("midjob_reset_outputs", {2'd0, hash_enable, nonce_out, result_valid, result_found,
                                     result_timeout, result_nonce, busy, job_ready}, 72'd1);
        n_rst = 1'b1;
        wait_fin(200);
        tick();
        tick();
        chk("stray_finished_ignored", {68'd0, busy, result_valid, hash_enable, job_ready}, 72'b0001);

        repeat (3) tick();
        chk("launch_queue_drained", 72'(exp_nonce.size()), 72'd0);
        chk("result_queue_drained", 72'(exp_res.size()), 72'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
